// File: rtl/sgpr_replay_rf.sv
// sgpr_replay_rf: 32x32 register file with x0 hard-wired to zero and a shadow bank one committed write behind for replay rollback
module sgpr_replay_rf #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  test_en_i,
    input  logic [ADDR_WIDTH-1:0] raddr_a_i,
    output logic [DATA_WIDTH-1:0] rdata_a_o,
    input  logic [ADDR_WIDTH-1:0] raddr_b_i,
    output logic [DATA_WIDTH-1:0] rdata_b_o,
    input  logic [ADDR_WIDTH-1:0] waddr_a_i,
    input  logic [DATA_WIDTH-1:0] wdata_a_i,
    input  logic                  we_a_i,
    input  logic                  replay
);
    localparam int NREG = 2 ** ADDR_WIDTH;
    logic [DATA_WIDTH-1:0] main_bank   [1:NREG-1];
    logic [DATA_WIDTH-1:0] shadow_bank [1:NREG-1];
    logic                  p_valid;
    logic [ADDR_WIDTH-1:0] p_addr;
    logic [DATA_WIDTH-1:0] p_data;
    logic                  wr_ok;
    logic                  unused_test_en;
    assign unused_test_en = test_en_i;
    assign wr_ok = we_a_i && (waddr_a_i != '0);
    // rst_n is active-high despite its name
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int i = 1; i < NREG; i++) begin
                main_bank[i]   <= '0;
                shadow_bank[i] <= '0;
            end
            p_valid <= 1'b0;
            p_addr  <= '0;
            p_data  <= '0;
        end else if (replay) begin
            for (int i = 1; i < NREG; i++)
                main_bank[i] <= shadow_bank[i];
            p_valid <= 1'b0;
        end else begin
            // the previous write becomes the checkpoint as soon as another non-replay edge passes
            if (p_valid)
                shadow_bank[p_addr] <= p_data;
            if (wr_ok) begin
                main_bank[waddr_a_i] <= wdata_a_i;
                p_addr               <= waddr_a_i;
                p_data               <= wdata_a_i;
            end
            p_valid <= wr_ok;
        end
    end
    assign rdata_a_o = (raddr_a_i == '0) ? '0 : main_bank[raddr_a_i];
    assign rdata_b_o = (raddr_b_i == '0) ? '0 : main_bank[raddr_b_i];
endmodule

// File: tb/tb_sgpr_replay_rf.sv
// tb_sgpr_replay_rf: scoreboard bench for sgpr_replay_rf; directed scenarios with fixed expectations, then a random phase against a reference model
module tb_sgpr_replay_rf;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        test_en_i = 1'b0;
    logic [4:0]  raddr_a_i = '0;
    logic [31:0] rdata_a_o;
    logic [4:0]  raddr_b_i = '0;
    logic [31:0] rdata_b_o;
    logic [4:0]  waddr_a_i = '0;
    logic [31:0] wdata_a_i = '0;
    logic        we_a_i = 1'b0;
    logic        replay = 1'b0;

    int total = 0;
    int bad = 0;
    logic [31:0] exp_q [$];

    logic [31:0] mm [32];
    logic [31:0] ss [32];
    logic        pv;
    logic [4:0]  pa;
    logic [31:0] pd;

    sgpr_replay_rf dut (
        .clk(clk), .rst_n(rst_n), .test_en_i(test_en_i),
        .raddr_a_i(raddr_a_i), .rdata_a_o(rdata_a_o),
        .raddr_b_i(raddr_b_i), .rdata_b_o(rdata_b_o),
        .waddr_a_i(waddr_a_i), .wdata_a_i(wdata_a_i),
        .we_a_i(we_a_i), .replay(replay)
    );

    always #5 clk = ~clk;

    // reference model of the architectural behaviour, used by the random phase
    always @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int i = 0; i < 32; i++) begin
                mm[i] <= '0;
                ss[i] <= '0;
            end
            pv <= 1'b0;
            pa <= '0;
            pd <= '0;
        end else if (replay) begin
            for (int i = 1; i < 32; i++)
                mm[i] <= ss[i];
            pv <= 1'b0;
        end else begin
            if (pv)
                ss[pa] <= pd;
            if (we_a_i && waddr_a_i != 5'd0) begin
                mm[waddr_a_i] <= wdata_a_i;
                pa <= waddr_a_i;
                pd <= wdata_a_i;
                pv <= 1'b1;
            end else begin
                pv <= 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drain(input string tag);
        logic [31:0] ea, eb;
        if (exp_q.size() < 2) begin
            chk({tag, "_q_empty"}, 32'(exp_q.size()), 32'd2);
        end else begin
            ea = exp_q.pop_front();
            eb = exp_q.pop_front();
            chk({tag, "_a"}, rdata_a_o, ea);
            chk({tag, "_b"}, rdata_b_o, eb);
        end
    endtask

    task automatic rd(input string tag, input logic [4:0] a, input logic [4:0] b,
                      input logic [31:0] ea, input logic [31:0] eb);
        @(negedge clk);
        raddr_a_i = a;
        raddr_b_i = b;
        exp_q.push_back(ea);
        exp_q.push_back(eb);
        #1;
        drain(tag);
    endtask

    task automatic rdm(input string tag, input logic [4:0] a, input logic [4:0] b);
        @(negedge clk);
        raddr_a_i = a;
        raddr_b_i = b;
        exp_q.push_back(a == 5'd0 ? 32'd0 : mm[a]);
        exp_q.push_back(b == 5'd0 ? 32'd0 : mm[b]);
        #1;
        drain(tag);
    endtask

    task automatic op(input logic w, input logic [4:0] a, input logic [31:0] d, input logic r);
        @(negedge clk);
        we_a_i = w;
        waddr_a_i = a;
        wdata_a_i = d;
        replay = r;
        @(posedge clk);
        #1;
        we_a_i = 1'b0;
        replay = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        for (int i = 0; i < 32; i++)
            rd("rst_held", 5'(i), 5'(31 - i), 32'd0, 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        rd("rst_rel", 5'd1, 5'd31, 32'd0, 32'd0);

        for (int i = 1; i < 32; i++) begin
            test_en_i = i[0];
            op(1'b1, 5'(i), 32'(i), 1'b0);
        end
        for (int i = 1; i < 32; i++)
            rd("fill", 5'(i), 5'(32 - i), 32'(i), 32'(32 - i));

        op(1'b1, 5'd0, 32'd100, 1'b0);
        rd("x0", 5'd0, 5'd0, 32'd0, 32'd0);
        rd("x0_keep", 5'd1, 5'd31, 32'd1, 32'd31);

        do_reset();
        op(1'b1, 5'd10, 32'd100, 1'b0);
        op(1'b0, 5'd0, 32'd0, 1'b0);
        op(1'b1, 5'd10, 32'd200, 1'b0);
        op(1'b0, 5'd0, 32'd0, 1'b1);
        rd("undo", 5'd10, 5'd10, 32'd100, 32'd100);
        op(1'b1, 5'd12, 32'd100, 1'b0);
        op(1'b0, 5'd0, 32'd0, 1'b1);
        rd("undo_nocommit", 5'd12, 5'd10, 32'd0, 32'd100);

        test_en_i = 1'b1;
        op(1'b1, 5'd5, 32'd55, 1'b1);
        rd("replay_blocks_we", 5'd5, 5'd0, 32'd0, 32'd0);
        op(1'b1, 5'd6, 32'd66, 1'b0);
        repeat (3) op(1'b0, 5'd0, 32'd0, 1'b1);
        rd("replay_multi", 5'd6, 5'd10, 32'd0, 32'd100);
        op(1'b1, 5'd7, 32'd70, 1'b0);
        op(1'b0, 5'd0, 32'd0, 1'b0);
        op(1'b0, 5'd0, 32'd0, 1'b1);
        rd("replay_idle", 5'd7, 5'd12, 32'd70, 32'd0);
        test_en_i = 1'b0;

        @(negedge clk);
        we_a_i = 1'b1;
        waddr_a_i = 5'd7;
        wdata_a_i = 32'd77;
        raddr_a_i = 5'd7;
        raddr_b_i = 5'd7;
        exp_q.push_back(32'd70);
        exp_q.push_back(32'd70);
        #1;
        drain("same_pre");
        @(posedge clk);
        #1;
        we_a_i = 1'b0;
        exp_q.push_back(32'd77);
        exp_q.push_back(32'd77);
        drain("same_post");

        @(negedge clk);
        we_a_i = 1'b1;
        waddr_a_i = 5'd3;
        wdata_a_i = 32'd33;
        replay = 1'b1;
        #2;
        rst_n = 1'b1;
        raddr_a_i = 5'd7;
        raddr_b_i = 5'd10;
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        #1;
        drain("rst_async");
        @(posedge clk);
        #1;
        raddr_a_i = 5'd3;
        raddr_b_i = 5'd7;
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        #1;
        drain("rst_override");
        @(negedge clk);
        we_a_i = 1'b0;
        replay = 1'b0;
        rst_n = 1'b0;
        rd("rst_after", 5'd3, 5'd7, 32'd0, 32'd0);

        for (int n = 0; n < 300; n++) begin
            int k;
            k = $urandom_range(0, 9);
            test_en_i = 1'($urandom);
            if (k < 6)
                op(1'b1, 5'($urandom_range(0, 31)), $urandom, 1'b0);
            else if (k < 8)
                op(1'b0, 5'd0, 32'd0, 1'b0);
            else
                op(1'($urandom), 5'($urandom_range(1, 31)), $urandom, 1'b1);
            if (n % 4 == 3)
                rdm("rand", 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        end
        for (int i = 0; i < 32; i++)
            rdm("rand_sweep", 5'(i), 5'(31 - i));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
